axi4_s_w: RTL and testbench

AXI4 write-channel slave that terminates bursts issued by the bridge's AXI4 write master and hands each completed burst to the host-side model. It accepts one AW, buffers the W beats (data plus strobes), and presents a burst descriptor with a random-access beat read port. It returns the B response only after the consumer accepts the descriptor. One burst is in flight at a time.

---
 rtl/axi4_s_w_if.sv | 58 +++++
 rtl/axi4_s_w.sv | 205 ++++++++++++++++++++
 tb/tb_axi4_s_w.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_s_w_if.sv
// ============================================================================
// Module      : axi4_s_w_if
// Description : AXI4 write-channel bundle (AW, W, B) between the bridge's
//               write master and the axi4_s_w terminating slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi4_s_w_if #(
  parameter int TAGW = 3,
  parameter int ADRW = 32,
  parameter int DATW = 256,
  parameter int STBW = DATW / 8
);

  // Write address channel
  logic [TAGW-1:0] awid;
  logic [ADRW-1:0] awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  // Write data channel
  logic [DATW-1:0] wdata;
  logic [STBW-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  // Write response channel
  logic [TAGW-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

`default_nettype wire

// File: rtl/axi4_s_w.sv
// ============================================================================
// Module      : axi4_s_w
// Description : AXI4 write slave. Accepts one AW, buffers the W beats (data
//               and strobes), presents a burst descriptor with a synchronous
//               random-access beat read port, and returns B only after the
//               consumer takes the descriptor. One burst in flight at a time.
//               Optional macro AXI4_S_W_WLAST_CHECK_EN flags wlast/len
//               disagreement as a burst error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_s_w #(
  parameter int TAGW = 3,
  parameter int ADRW = 32,
  parameter int DATW = 256,
  parameter int STBW = DATW / 8,
  parameter int NBUF = 16,
  parameter int IDXW = $clog2(NBUF)
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst,
  axi4_s_w_if.slave            s,
  output logic [ADRW-1:0]      o_desc_addr,
  output logic [7:0]           o_desc_len,
  output logic [2:0]           o_desc_size,
  output logic                 o_desc_err,
  output logic                 o_desc_valid,
  input  wire logic            i_desc_ready,
  input  wire logic [IDXW-1:0] i_rd_idx,
  output logic [DATW-1:0]      o_rd_data,
  output logic [STBW-1:0]      o_rd_strb
);

  localparam logic [8:0] C_NBUF = 9'(NBUF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DESC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [TAGW-1:0] r_id;
  logic [ADRW-1:0] r_addr;
  logic [7:0]      r_len;
  logic [2:0]      r_size;
  logic            r_err;
  logic [8:0]      r_cnt;      // 9 bits so a 256-beat burst never wraps

  logic [DATW-1:0] r_mem      [NBUF];
  logic [STBW-1:0] r_mem_strb [NBUF];
  logic [NBUF-1:0] r_vld;      // entry written since reset; unwritten reads give 0
  logic [DATW-1:0] r_rd_data;
  logic [STBW-1:0] r_rd_strb;

  logic            w_awready;
  logic            w_wready;
  logic            w_desc_valid;
  logic            w_bvalid;
  logic            w_aw_acc;
  logic            w_w_acc;
  logic            w_last;
  logic            w_in_range;
  logic            w_err_set;
  logic [IDXW-1:0] w_wr_idx;
  logic            w_unused;

  // Handshakes qualified by state; reset suppresses any acceptance
  assign w_aw_acc   = s.awvalid & (r_state == ST_IDLE) & ~i_rst;
  assign w_w_acc    = s.wvalid  & (r_state == ST_DATA) & ~i_rst;
  assign w_last     = (r_cnt == {1'b0, r_len});
  assign w_in_range = (r_cnt < C_NBUF);
  assign w_wr_idx   = r_cnt[IDXW-1:0];

`ifdef AXI4_S_W_WLAST_CHECK_EN
  // Beyond-buffer beats, and wlast disagreeing with the length count, are errors
  assign w_err_set  = ~w_in_range | (s.wlast != w_last);
`else
  // Only beats beyond the buffer are errors; wlast plays no part
  assign w_err_set  = ~w_in_range;
`endif

  // awburst is carried on the bus but deliberately not used
  assign w_unused   = ^{s.awburst, s.wlast};

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state handshake outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_desc_valid = 1'b0;
    w_bvalid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_awready = ~i_rst;
        if (s.awvalid) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_wready = 1'b1;
        if (s.wvalid && w_last) w_state_nxt = ST_DESC;
      end
      ST_DESC: begin
        w_desc_valid = 1'b1;
        if (i_desc_ready) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_bvalid = 1'b1;
        if (s.bready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Burst capture, beat counting and error accumulation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_id   <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_size <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (w_aw_acc) begin
      r_id   <= s.awid;
      r_addr <= s.awaddr;
      r_len  <= s.awlen;
      r_size <= s.awsize;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (w_w_acc) begin
      r_cnt <= r_cnt + 9'd1;
      if (w_err_set) r_err <= 1'b1;
    end
  end

`ifdef AXI4_S_W_WLAST_CHECK_EN
  // Report wlast/length disagreement as it is accepted
  always_ff @(posedge i_clk) begin
    if (w_w_acc && (s.wlast != w_last)) begin
      $error("axi4_s_w: wlast mismatch at beat %0d of burst at address 0x%h", r_cnt, r_addr);
    end
  end
`endif

  // Beat storage; no reset so it can map onto RAM
  always_ff @(posedge i_clk) begin
    if (w_w_acc && w_in_range) begin
      r_mem[w_wr_idx]      <= s.wdata;
      r_mem_strb[w_wr_idx] <= s.wstrb;
    end
  end

  // Written-entry flags, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
    end else if (w_w_acc && w_in_range) begin
      r_vld[w_wr_idx] <= 1'b1;
    end
  end

  // Registered beat read port
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
      r_rd_strb <= '0;
    end else if (r_vld[i_rd_idx]) begin
      r_rd_data <= r_mem[i_rd_idx];
      r_rd_strb <= r_mem_strb[i_rd_idx];
    end else begin
      r_rd_data <= '0;
      r_rd_strb <= '0;
    end
  end

  assign s.awready    = w_awready;
  assign s.wready     = w_wready;
  assign s.bvalid     = w_bvalid;
  assign s.bid        = r_id;
  assign s.bresp      = r_err ? 2'b10 : 2'b00;

  assign o_desc_valid = w_desc_valid;
  assign o_desc_addr  = r_addr;
  assign o_desc_len   = r_len;
  assign o_desc_size  = r_size;
  assign o_desc_err   = r_err;
  assign o_rd_data    = r_rd_data;
  assign o_rd_strb    = r_rd_strb;

endmodule

`default_nettype wire

// File: tb/tb_axi4_s_w.sv
// ============================================================================
// Module      : tb_axi4_s_w
// Description : Self-checking bench for axi4_s_w with a cycle-level
//               behavioural model and directed bursts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_s_w;

  localparam int TAGW = 3;
  localparam int ADRW = 32;
  localparam int DATW = 256;
  localparam int STBW = DATW / 8;
  localparam int NBUF = 16;
  localparam int IDXW = $clog2(NBUF);
`ifdef AXI4_S_W_WLAST_CHECK_EN
  localparam bit WLC = 1'b1;
`else
  localparam bit WLC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [ADRW-1:0] desc_addr;
  logic [7:0]      desc_len;
  logic [2:0]      desc_size;
  logic            desc_err;
  logic            desc_valid;
  logic            desc_ready;
  logic [IDXW-1:0] rd_idx;
  logic [DATW-1:0] rd_data;
  logic [STBW-1:0] rd_strb;

  int checks = 0;
  int errors = 0;

  axi4_s_w_if #(.TAGW(TAGW), .ADRW(ADRW), .DATW(DATW), .STBW(STBW)) ifc ();

  axi4_s_w #(
    .TAGW(TAGW), .ADRW(ADRW), .DATW(DATW), .STBW(STBW), .NBUF(NBUF), .IDXW(IDXW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .s            (ifc),
    .o_desc_addr  (desc_addr),
    .o_desc_len   (desc_len),
    .o_desc_size  (desc_size),
    .o_desc_err   (desc_err),
    .o_desc_valid (desc_valid),
    .i_desc_ready (desc_ready),
    .i_rd_idx     (rd_idx),
    .o_rd_data    (rd_data),
    .o_rd_strb    (rd_strb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DATW-1:0] act, input logic [DATW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL timeout waiting for %s (t=%0t)", nm, $time);
  endtask

  // ---------------- behavioural model ----------------
  int              m_ph = 0;      // 0 idle, 1 collecting beats, 2 descriptor, 3 response
  bit              m_known = 1'b0;
  logic [TAGW-1:0] m_id;
  logic [ADRW-1:0] m_addr;
  logic [7:0]      m_len;
  logic [2:0]      m_size;
  bit              m_err;
  int              m_cnt;
  logic [DATW-1:0] m_mem  [NBUF];
  logic [STBW-1:0] m_strb [NBUF];
  logic [NBUF-1:0] m_wr;
  logic [DATW-1:0] m_rd_d;
  logic [STBW-1:0] m_rd_s;
  bit              m_rd_skip;

  // Compare DUT against the model mid-cycle, then advance the model across the next edge
  always @(negedge clk) begin
    if (m_known) begin
      chk("awready", ifc.awready, (m_ph == 0) && !rst);
      chk("wready", ifc.wready, m_ph == 1);
      chk("desc_valid", desc_valid, m_ph == 2);
      chk("bvalid", ifc.bvalid, m_ph == 3);
      if (m_ph == 2) begin
        chk("desc_addr", desc_addr, m_addr);
        chk("desc_len", desc_len, m_len);
        chk("desc_size", desc_size, m_size);
        chk("desc_err", desc_err, m_err);
      end
      if (m_ph == 3) begin
        chk("bid", ifc.bid, m_id);
        chk("bresp", ifc.bresp, m_err ? 2'b10 : 2'b00);
      end
      if (!m_rd_skip) begin
        chk("rd_data", rd_data, m_rd_d);
        chk("rd_strb", rd_strb, m_rd_s);
      end
    end
    m_rd_skip = 1'b0;
    if (rst) begin
      m_ph = 0; m_err = 1'b0; m_id = '0; m_addr = '0; m_len = '0; m_size = '0;
      m_cnt = 0; m_wr = '0; m_rd_d = '0; m_rd_s = '0; m_known = 1'b1;
    end else if (m_known) begin
      m_rd_d = m_wr[rd_idx] ? m_mem[rd_idx] : '0;
      m_rd_s = m_wr[rd_idx] ? m_strb[rd_idx] : '0;
      case (m_ph)
        0: if (ifc.awvalid) begin
          m_id = ifc.awid; m_addr = ifc.awaddr; m_len = ifc.awlen; m_size = ifc.awsize;
          m_cnt = 0; m_err = 1'b0; m_ph = 1;
        end
        1: if (ifc.wvalid) begin
          if (m_cnt < NBUF) begin
            if (m_cnt == int'(rd_idx)) m_rd_skip = 1'b1;
            m_mem[m_cnt] = ifc.wdata; m_strb[m_cnt] = ifc.wstrb; m_wr[m_cnt] = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          if (WLC && (ifc.wlast != (m_cnt == int'(m_len)))) m_err = 1'b1;
          if (m_cnt == int'(m_len)) m_ph = 2;
          m_cnt++;
        end
        2: if (desc_ready) m_ph = 3;
        3: if (ifc.bready) m_ph = 0;
        default: m_ph = 0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  logic [DATW-1:0] bd [32];
  logic [STBW-1:0] bs [32];

  // Issue AW together with the first W beat; send nb beats, wlast on beat wl
  task automatic burst(input logic [TAGW-1:0] id, input logic [ADRW-1:0] addr,
                       input logic [7:0] len, input logic [2:0] size, input int wl, input int nb);
    int n;
    ifc.awid = id; ifc.awaddr = addr; ifc.awlen = len; ifc.awsize = size;
    ifc.awburst = 2'b01; ifc.awvalid = 1'b1;
    ifc.wdata = bd[0]; ifc.wstrb = bs[0]; ifc.wlast = (wl == 0); ifc.wvalid = 1'b1;
    n = 0;
    while (!ifc.awready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) timeout("awready");
    @(posedge clk); #1;
    ifc.awvalid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      ifc.wdata = bd[b]; ifc.wstrb = bs[b]; ifc.wlast = (b == wl); ifc.wvalid = 1'b1;
      n = 0;
      while (!ifc.wready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) timeout("wready");
      @(posedge clk); #1;
    end
    ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
  endtask

  task automatic wait_desc();
    int n = 0;
    while (!desc_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) timeout("desc_valid");
  endtask

  task automatic give_desc(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    desc_ready = 1'b1;
    @(posedge clk); #1;
    desc_ready = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    while (!ifc.bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) timeout("bvalid");
  endtask

  task automatic give_b(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    ifc.bready = 1'b1;
    @(posedge clk); #1;
    ifc.bready = 1'b0;
  endtask

  task automatic rd_check(input int i, input logic [DATW-1:0] d, input logic [STBW-1:0] st);
    rd_idx = IDXW'(i);
    @(posedge clk); #1;
    chk($sformatf("rd_data_lit[%0d]", i), rd_data, d);
    chk($sformatf("rd_strb_lit[%0d]", i), rd_strb, st);
  endtask

  task automatic reset_vals();
    chk("rst_awready", ifc.awready, 1'b0);
    chk("rst_wready", ifc.wready, 1'b0);
    chk("rst_bvalid", ifc.bvalid, 1'b0);
    chk("rst_desc_valid", desc_valid, 1'b0);
    chk("rst_desc_err", desc_err, 1'b0);
    chk("rst_bresp", ifc.bresp, 2'b00);
    chk("rst_bid", ifc.bid, 3'd0);
    chk("rst_desc_addr", desc_addr, 32'd0);
    chk("rst_desc_len", desc_len, 8'd0);
    chk("rst_desc_size", desc_size, 3'd0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_rd_strb", rd_strb, '0);
  endtask

  initial begin
    rst = 1'b1; desc_ready = 1'b0; rd_idx = '0;
    ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0;
    ifc.awvalid = 1'b0; ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0;
    ifc.wvalid = 1'b0; ifc.bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_vals();
    rst = 1'b0;
    @(posedge clk); #1;

    // Single beat, narrow size forwarded unchanged
    bd[0] = {8{32'hA5A5_0001}}; bs[0] = '1;
    burst(3'd3, 32'h0000_1000, 8'd0, 3'd2, 0, 1);
    wait_desc();
    chk("t1_desc_addr", desc_addr, 32'h0000_1000);
    chk("t1_desc_len", desc_len, 8'd0);
    chk("t1_desc_size", desc_size, 3'd2);
    chk("t1_desc_err", desc_err, 1'b0);
    give_desc(0);
    wait_b();
    chk("t1_bid", ifc.bid, 3'd3);
    chk("t1_bresp", ifc.bresp, 2'b00);
    give_b(0);
    rd_check(0, {8{32'hA5A5_0001}}, 32'hFFFF_FFFF);

    // Four beats, partial strobe on beat 2
    for (int k = 0; k < 4; k++) begin bd[k] = {8{32'h2000_0000 | 32'(k)}}; bs[k] = '1; end
    bs[2] = 32'h0000_FFFF;
    burst(3'd5, 32'h0000_2000, 8'd3, 3'd5, 3, 4);
    chk("t2_wready_after_last", ifc.wready, 1'b0);
    chk("t2_desc_valid_after_last", desc_valid, 1'b1);
    wait_desc();
    chk("t2_desc_len", desc_len, 8'd3);
    give_desc(0);
    wait_b();
    chk("t2_bresp", ifc.bresp, 2'b00);
    give_b(0);
    rd_check(0, {8{32'h2000_0000}}, 32'hFFFF_FFFF);
    rd_check(1, {8{32'h2000_0001}}, 32'hFFFF_FFFF);
    rd_check(2, {8{32'h2000_0002}}, 32'h0000_FFFF);
    rd_check(3, {8{32'h2000_0003}}, 32'hFFFF_FFFF);

    // Overlong burst: 17 beats into a 16-entry buffer
    for (int k = 0; k < 17; k++) begin bd[k] = {8{32'h3000_0000 | 32'(k)}}; bs[k] = 32'(k + 1); end
    burst(3'd1, 32'h0000_3000, 8'd16, 3'd5, 16, 17);
    wait_desc();
    chk("t3_desc_err", desc_err, 1'b1);
    give_desc(0);
    wait_b();
    chk("t3_bresp", ifc.bresp, 2'b10);
    give_b(0);
    rd_check(0, {8{32'h3000_0000}}, 32'd1);
    rd_check(15, {8{32'h3000_000F}}, 32'd16);

    // Early wlast on beat 1 of a 3-beat burst
    for (int k = 0; k < 3; k++) begin bd[k] = {8{32'h4000_0000 | 32'(k)}}; bs[k] = '1; end
    burst(3'd2, 32'h0000_4000, 8'd2, 3'd5, 1, 3);
    wait_desc();
    chk("t4_desc_err", desc_err, WLC);
    give_desc(0);
    wait_b();
    chk("t4_bresp", ifc.bresp, WLC ? 2'b10 : 2'b00);
    give_b(0);

    // Consumer and B stalls; model checks stability every cycle
    for (int k = 0; k < 2; k++) begin bd[k] = {8{32'h5000_0000 | 32'(k)}}; bs[k] = '1; end
    burst(3'd6, 32'h0000_5000, 8'd1, 3'd5, 1, 2);
    wait_desc();
    give_desc(10);
    wait_b();
    chk("t5_awready_during_b", ifc.awready, 1'b0);
    give_b(5);
    chk("t5_awready_after_b", ifc.awready, 1'b1);

    // Reset after two beats of a four-beat burst, then a clean burst
    for (int k = 0; k < 4; k++) begin bd[k] = {8{32'h6000_0000 | 32'(k)}}; bs[k] = '1; end
    burst(3'd4, 32'h0000_6000, 8'd3, 3'd5, 3, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    reset_vals();
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin bd[k] = {8{32'h7000_0000 | 32'(k)}}; bs[k] = 32'h00FF_00FF; end
    burst(3'd7, 32'h0000_7000, 8'd1, 3'd5, 1, 2);
    wait_desc();
    chk("t6_desc_addr", desc_addr, 32'h0000_7000);
    chk("t6_desc_err", desc_err, 1'b0);
    give_desc(0);
    wait_b();
    chk("t6_bid", ifc.bid, 3'd7);
    chk("t6_bresp", ifc.bresp, 2'b00);
    give_b(0);
    rd_check(1, {8{32'h7000_0001}}, 32'h00FF_00FF);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
